// File: rtl/tribus_receiver.sv
// Receive-side controller for a shared tri-state bus: grants one inverting driver at a time,
// samples and un-inverts the bus after a settle time, and feeds a bus keeper when no driver is enabled.
module tribus_receiver #(
    parameter int W      = 8,
    parameter int N      = 4,
    parameter int SETTLE = 1,
    parameter int GAP    = 1
) (
    input  logic                 CLK,
    input  logic                 RN,
    input  logic [N-1:0]         REQ,
    output logic [N-1:0]         EN,
    input  logic [W-1:0]         BUS,
    output logic [W-1:0]         Q,
    output logic                 QV,
    input  logic                 QR,
    output logic [$clog2(N)-1:0] QSRC,
    output logic [W-1:0]         KEEP,
    output logic                 KEEP_EN,
    output logic [1:0]           dbg_state
);

    localparam int PW   = $clog2(N);
    localparam int CMAX = (SETTLE > GAP) ? SETTLE : GAP;
    localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_GRANT = 2'd1,
        S_OUT   = 2'd2,
        S_GAP   = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [N-1:0]    en_q, en_d;
    logic [W-1:0]    q_q, q_d;
    logic            qv_q, qv_d;
    logic [PW-1:0]   qsrc_q, qsrc_d;
    logic [W-1:0]    keep_q, keep_d;
    logic [PW-1:0]   ptr_q, ptr_d;
    logic [CW-1:0]   cnt_q, cnt_d;

    logic [PW-1:0]   ptr_inc;
    logic [PW-1:0]   arb_ptr;
    logic [N-1:0]    req_rot;
    logic            pick_found;
    logic [PW-1:0]   pick_idx;
    logic            arb_now;
    logic            hs;

    function automatic logic [PW-1:0] wrap_add(input logic [PW-1:0] base, input logic [PW-1:0] off);
        logic [PW:0] sum;
        sum = {1'b0, base} + {1'b0, off};
        if (sum >= (PW+1)'(N)) begin
            sum = sum - (PW+1)'(N);
        end
        return sum[PW-1:0];
    endfunction

    assign hs      = qv_q && QR;
    assign ptr_inc = wrap_add(qsrc_q, PW'(1));

    // With no turnaround, the handshake edge itself arbitrates, so it must see the advanced pointer.
    assign arb_ptr = (state_q == S_OUT) ? ptr_inc : ptr_q;

    always_comb begin
        req_rot    = N'({REQ, REQ} >> arb_ptr);
        pick_found = 1'b0;
        pick_idx   = '0;
        for (int j = N - 1; j >= 0; j--) begin
            if (req_rot[j]) begin
                pick_found = 1'b1;
                pick_idx   = wrap_add(arb_ptr, PW'(j));
            end
        end
    end

    always_comb begin
        state_d = state_q;
        en_d    = en_q;
        q_d     = q_q;
        qv_d    = qv_q;
        qsrc_d  = qsrc_q;
        keep_d  = keep_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        arb_now = 1'b0;

        case (state_q)
            S_IDLE: begin
                arb_now = 1'b1;
            end
            S_GRANT: begin
                if (cnt_q == '0) begin
                    q_d     = ~BUS;
                    keep_d  = BUS;
                    qv_d    = 1'b1;
                    en_d    = '0;
                    state_d = S_OUT;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_OUT: begin
                if (hs) begin
                    qv_d  = 1'b0;
                    ptr_d = ptr_inc;
                    if (GAP == 0) begin
                        arb_now = 1'b1;
                    end else begin
                        cnt_d   = CW'(GAP - 1);
                        state_d = S_GAP;
                    end
                end
            end
            S_GAP: begin
                // The edge closing the last turnaround cycle doubles as the arbitration edge.
                if (cnt_q == '0) begin
                    arb_now = 1'b1;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                en_d    = '0;
            end
        endcase

        if (arb_now) begin
            if (pick_found) begin
                en_d    = N'(1) << pick_idx;
                qsrc_d  = pick_idx;
                cnt_d   = CW'(SETTLE - 1);
                state_d = S_GRANT;
            end else begin
                state_d = S_IDLE;
            end
        end
    end

    // Async clear of EN releases the bus to the keeper without waiting for a clock.
    always_ff @(posedge CLK or negedge RN) begin
        if (!RN) begin
            state_q <= S_IDLE;
            en_q    <= '0;
            q_q     <= '0;
            qv_q    <= 1'b0;
            qsrc_q  <= '0;
            keep_q  <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            en_q    <= en_d;
            q_q     <= q_d;
            qv_q    <= qv_d;
            qsrc_q  <= qsrc_d;
            keep_q  <= keep_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
        end
    end

    assign EN        = en_q;
    assign Q         = q_q;
    assign QV        = qv_q;
    assign QSRC      = qsrc_q;
    assign KEEP      = keep_q;
    assign KEEP_EN   = ~|en_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_tribus_receiver.sv
// Bench for tribus_receiver: inverting drivers and a keeper model the bus; expected words are
// queued as requests are driven and compared when the consumer handshake happens.
module tb_tribus_receiver;

    localparam int W  = 8;
    localparam int N  = 4;
    localparam int PW = 2;

    // clock / reset
    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    int unsigned cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    logic [W-1:0] drv_data [N];

    // instance A: SETTLE=1, GAP=1
    logic          rn_a, qv_a, qr_a, keep_en_a;
    logic [N-1:0]  req_a, en_a;
    logic [W-1:0]  bus_a, q_a, keep_a;
    logic [PW-1:0] qsrc_a;
    logic [1:0]    dbg_a;

    // instance B: SETTLE=3, GAP=1
    logic          rn_b, qv_b, qr_b, keep_en_b;
    logic [N-1:0]  req_b, en_b;
    logic [W-1:0]  bus_b, q_b, keep_b;
    logic [PW-1:0] qsrc_b;
    logic [1:0]    dbg_b;

    tribus_receiver #(.W(W), .N(N), .SETTLE(1), .GAP(1)) u_dut_a (
        .CLK(CLK), .RN(rn_a), .REQ(req_a), .EN(en_a), .BUS(bus_a), .Q(q_a), .QV(qv_a),
        .QR(qr_a), .QSRC(qsrc_a), .KEEP(keep_a), .KEEP_EN(keep_en_a), .dbg_state(dbg_a)
    );

    tribus_receiver #(.W(W), .N(N), .SETTLE(3), .GAP(1)) u_dut_b (
        .CLK(CLK), .RN(rn_b), .REQ(req_b), .EN(en_b), .BUS(bus_b), .Q(q_b), .QV(qv_b),
        .QR(qr_b), .QSRC(qsrc_b), .KEEP(keep_b), .KEEP_EN(keep_en_b), .dbg_state(dbg_b)
    );

    // Enabled driver puts its inverted word on the bus; otherwise the keeper holds the level.
    always_comb begin
        bus_a = keep_a;
        for (int i = 0; i < N; i++) if (en_a[i]) bus_a = ~drv_data[i];
    end
    always_comb begin
        bus_b = keep_b;
        for (int i = 0; i < N; i++) if (en_b[i]) bus_b = ~drv_data[i];
    end

    // scoreboard
    logic [PW+2*W-1:0] exp_q[$];
    int unsigned       hs_cyc[$];
    int                n_checks = 0;
    int                n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    always @(negedge CLK) begin
        logic [PW+2*W-1:0] e;
        if (rn_a) begin
            check("en_onehot0", 32'($onehot0(en_a)), 32'd1);
            check("en_qv_excl", 32'((|en_a) && qv_a), 32'd0);
            check("keep_en", 32'(keep_en_a), 32'(en_a == '0));
            if (qv_a && qr_a) begin
                check("word_expected", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("sb_qsrc", 32'(qsrc_a), 32'(e[PW+2*W-1:2*W]));
                    check("sb_q", 32'(q_a), 32'(e[2*W-1:W]));
                    check("sb_keep", 32'(keep_a), 32'(e[W-1:0]));
                    hs_cyc.push_back(cyc);
                end
            end
        end
    end

    // driver tasks
    task automatic wait_drain(input int limit);
        int k = 0;
        while (exp_q.size() != 0 && k < limit) begin
            @(negedge CLK); #1;
            k++;
        end
        check("drain_timeout", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic wait_idle_a(input int limit);
        int k = 0;
        while ((dbg_a != 2'd0 || qv_a) && k < limit) begin
            @(posedge CLK); #1;
            k++;
        end
        check("idle_timeout", 32'(dbg_a), 32'd0);
    endtask

    task automatic wait_qv_a(input int limit);
        int k = 0;
        while (!qv_a && k < limit) begin
            @(posedge CLK); #1;
            k++;
        end
        check("qv_timeout", 32'(qv_a), 32'd1);
    endtask

    task automatic wait_en_a(input int limit);
        int k = 0;
        while (en_a == '0 && k < limit) begin
            @(posedge CLK); #1;
            k++;
        end
        check("grant_timeout", 32'(en_a != '0), 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int r;
        int k;
        rn_a = 1'b0; req_a = '0; qr_a = 1'b0;
        rn_b = 1'b0; req_b = '0; qr_b = 1'b0;
        drv_data[0] = 8'h11; drv_data[1] = 8'hA5; drv_data[2] = 8'h3C; drv_data[3] = 8'hC3;
        repeat (3) @(posedge CLK);
        #1;

        // reset state
        check("rst_en", 32'(en_a), 32'd0);
        check("rst_qv", 32'(qv_a), 32'd0);
        check("rst_q", 32'(q_a), 32'd0);
        check("rst_qsrc", 32'(qsrc_a), 32'd0);
        check("rst_keep", 32'(keep_a), 32'd0);
        check("rst_keep_en", 32'(keep_en_a), 32'd1);
        check("rst_state", 32'(dbg_a), 32'd0);

        // single request from driver 1, one settle cycle
        req_a = 4'b0010; rn_a = 1'b1;
        exp_q.push_back({2'd1, 8'hA5, 8'h5A});
        @(posedge CLK); #1;
        check("t1_en", 32'(en_a), 32'h2);
        check("t1_keep_en", 32'(keep_en_a), 32'd0);
        req_a = '0;
        @(posedge CLK); #1;
        check("t1_en_off", 32'(en_a), 32'd0);
        check("t1_qv", 32'(qv_a), 32'd1);
        check("t1_q", 32'(q_a), 32'hA5);
        check("t1_qsrc", 32'(qsrc_a), 32'd1);
        check("t1_keep", 32'(keep_a), 32'h5A);
        qr_a = 1'b1;
        wait_drain(20);
        wait_idle_a(20);
        qr_a = 1'b0;

        // all requesting after reset: round robin 0,1,2,3,0 at one word per 3 cycles
        rn_a = 1'b0;
        #5;
        check("t2_rst_en", 32'(en_a), 32'd0);
        check("t2_rst_state", 32'(dbg_a), 32'd0);
        @(posedge CLK); #1;
        hs_cyc.delete();
        exp_q.push_back({2'd0, 8'h11, 8'hEE});
        exp_q.push_back({2'd1, 8'hA5, 8'h5A});
        exp_q.push_back({2'd2, 8'h3C, 8'hC3});
        exp_q.push_back({2'd3, 8'hC3, 8'h3C});
        exp_q.push_back({2'd0, 8'h11, 8'hEE});
        req_a = 4'b1111; qr_a = 1'b1; rn_a = 1'b1;
        wait_drain(40);
        req_a = '0;
        check("t2_words", 32'(hs_cyc.size()), 32'd5);
        if (hs_cyc.size() >= 5) begin
            for (int i = 0; i < 4; i++) check("t2_period", 32'(hs_cyc[i+1] - hs_cyc[i]), 32'd3);
        end
        wait_idle_a(20);
        qr_a = 1'b0;

        // backpressure on driver 2, then wrap search from PTR=3 picks driver 1
        req_a = 4'b0100;
        exp_q.push_back({2'd2, 8'h3C, 8'hC3});
        wait_qv_a(20);
        req_a = 4'b0010;
        exp_q.push_back({2'd1, 8'hA5, 8'h5A});
        for (int i = 0; i < 5; i++) begin
            check("t3_hold_q", 32'(q_a), 32'h3C);
            check("t3_hold_qsrc", 32'(qsrc_a), 32'd2);
            check("t3_hold_qv", 32'(qv_a), 32'd1);
            check("t3_hold_en", 32'(en_a), 32'd0);
            @(posedge CLK); #1;
        end
        qr_a = 1'b1;
        @(posedge CLK); #1;
        check("t3_gap_en", 32'(en_a), 32'd0);
        check("t3_gap_state", 32'(dbg_a), 32'd3);
        @(posedge CLK); #1;
        check("t4_wrap_en", 32'(en_a), 32'h2);
        req_a = '0;
        wait_drain(20);
        wait_idle_a(20);
        qr_a = 1'b0;

        // driver 0 drops REQ after grant; QR already high before QV
        req_a = 4'b0001; qr_a = 1'b1;
        exp_q.push_back({2'd0, 8'h11, 8'hEE});
        @(posedge CLK); #1;
        check("t6_en", 32'(en_a), 32'h1);
        req_a = '0;
        @(posedge CLK); #1;
        check("t6_qv_first", 32'(qv_a), 32'd1);
        @(posedge CLK); #1;
        check("t6_qv_done", 32'(qv_a), 32'd0);
        wait_drain(10);
        wait_idle_a(20);
        qr_a = 1'b0;

        // random single requests with random data and consumer delay
        for (int it = 0; it < 8; it++) begin
            r = $urandom_range(0, N - 1);
            drv_data[r] = 8'($urandom_range(0, 255));
            exp_q.push_back({2'(r), drv_data[r], ~drv_data[r]});
            req_a = 4'b0001 << r;
            wait_en_a(10);
            req_a = '0;
            k = $urandom_range(0, 3);
            repeat (k) @(posedge CLK);
            #1;
            qr_a = 1'b1;
            wait_drain(20);
            wait_idle_a(20);
            qr_a = 1'b0;
        end

        // instance B: latency with SETTLE=3, then reset in the middle of a grant
        drv_data[0] = 8'h11; drv_data[1] = 8'hA5;
        @(posedge CLK); #1;
        rn_b = 1'b1; req_b = 4'b0010;
        k = 0;
        do begin
            @(posedge CLK); #1;
            k++;
        end while (!qv_b && k < 20);
        check("t5_latency", 32'(k), 32'd4);
        check("t5_q", 32'(q_b), 32'hA5);
        check("t5_qsrc", 32'(qsrc_b), 32'd1);
        check("t5_keep", 32'(keep_b), 32'h5A);
        qr_b = 1'b1; req_b = 4'b1001;
        @(posedge CLK); #1;
        check("t5_hs_qv", 32'(qv_b), 32'd0);
        qr_b = 1'b0;
        @(posedge CLK); #1;
        check("t5_grant3", 32'(en_b), 32'h8);
        @(posedge CLK); #1;
        check("t5_grant3_hold", 32'(en_b), 32'h8);
        #2;
        rn_b = 1'b0;
        #1;
        check("t5_async_en", 32'(en_b), 32'd0);
        check("t5_async_keep_en", 32'(keep_en_b), 32'd1);
        check("t5_async_qv", 32'(qv_b), 32'd0);
        check("t5_async_state", 32'(dbg_b), 32'd0);
        @(posedge CLK); #1;
        check("t5_rst_qv", 32'(qv_b), 32'd0);
        rn_b = 1'b1;
        @(posedge CLK); #1;
        check("t5_ptr0_grant", 32'(en_b), 32'h1);
        check("t5_ptr0_qv", 32'(qv_b), 32'd0);
        k = 0;
        while (!qv_b && k < 20) begin
            @(posedge CLK); #1;
            k++;
        end
        check("t5_q0", 32'(q_b), 32'h11);
        check("t5_qsrc0", 32'(qsrc_b), 32'd0);
        req_b = '0; qr_b = 1'b1;
        @(posedge CLK); #1;
        qr_b = 1'b0;

        // final report
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
